// File: rtl/cross_bar_resp_router.sv
// cross_bar_resp_router
//
// Read-response return path for one slave port of the crossbar. The order
// FIFO holds, in grant order, the master number of every outstanding read on
// this slave. Each slave response pops the FIFO head and is steered back to
// that master one cycle later. If the head waits TIMEOUT cycles without a
// response, the read is retired with an error response. The slave's eventual
// late answer to such a read is counted and silently discarded.
//
// Ports
//   clk          clock
//   aresetn      synchronous active-low reset
//   fifo_rd      pop the order FIFO head (combinational)
//   fifo_rdata   master number at the FIFO head
//   fifo_empty   order FIFO empty
//   s_resp       slave read-response valid (single-cycle pulse)
//   s_rdata      slave read data, valid with s_resp
//   m_resp       one-hot response strobe to the masters (registered)
//   m_rdata      response data shared by all masters (registered)
//   m_err        qualifies m_resp as a timeout error response (registered)
//   orphan_err   sticky: a response arrived with no outstanding read
//   late_pending late-response counter is nonzero
module cross_bar_resp_router #(
  parameter int MASTER_N = 4,
  parameter int MASTER_W = 2,
  parameter int DATA_W   = 32,
  parameter int TIMEOUT  = 64,
  parameter int LATE_W   = 4
) (
  input  logic                clk,
  input  logic                aresetn,
  output logic                fifo_rd,
  input  logic [MASTER_W-1:0] fifo_rdata,
  input  logic                fifo_empty,
  input  logic                s_resp,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic [MASTER_N-1:0] m_resp,
  output logic [DATA_W-1:0]   m_rdata,
  output logic                m_err,
  output logic                orphan_err,
  output logic                late_pending
);

  localparam int TIMER_W = $clog2(TIMEOUT);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [LATE_W-1:0]  LATE_MAX   = '1;

  logic [TIMER_W-1:0]  timer_reg, timer_next;
  logic [LATE_W-1:0]   late_cnt_reg, late_cnt_next;
  logic [MASTER_N-1:0] m_resp_reg;
  logic [DATA_W-1:0]   m_rdata_reg;
  logic                m_err_reg;
  logic                orphan_reg;

  logic                head_valid;
  logic                late_zero;
  logic                do_discard;
  logic                do_normal;
  logic                do_orphan;
  logic                do_timeout;
  logic                pop;
  logic [MASTER_N-1:0] head_onehot;

  assign head_valid = !fifo_empty;
  assign late_zero  = (late_cnt_reg == '0);

  // Mutually exclusive per-cycle actions. A response coinciding with timer
  // expiry wins over the timeout, so no error is issued in that race.
  assign do_discard = s_resp && !late_zero;
  assign do_normal  = s_resp &&  late_zero &&  head_valid;
  assign do_orphan  = s_resp &&  late_zero && !head_valid;
  assign do_timeout = !s_resp && head_valid && (timer_reg == TIMER_LAST);
  assign pop        = do_normal || do_timeout;

  // Gated by reset so the FIFO is never popped while this block is held.
  assign fifo_rd = aresetn && pop;

  genvar gi;
  generate
    for (gi = 0; gi < MASTER_N; gi++) begin : g_onehot
      assign head_onehot[gi] = (fifo_rdata == MASTER_W'(gi));
    end
  endgenerate

  always_comb begin
    timer_next    = timer_reg;
    late_cnt_next = late_cnt_reg;
    if (do_discard) begin
      late_cnt_next = late_cnt_reg - 1'b1;
      timer_next    = '0;
    end else if (do_normal || do_orphan) begin
      timer_next    = '0;
    end else if (do_timeout) begin
      if (late_cnt_reg != LATE_MAX) begin
        late_cnt_next = late_cnt_reg + 1'b1;
      end
      timer_next    = '0;
    end else if (head_valid) begin
      timer_next    = timer_reg + 1'b1;
    end else begin
      timer_next    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      timer_reg    <= '0;
      late_cnt_reg <= '0;
      m_resp_reg   <= '0;
      m_rdata_reg  <= '0;
      m_err_reg    <= 1'b0;
      orphan_reg   <= 1'b0;
    end else begin
      timer_reg    <= timer_next;
      late_cnt_reg <= late_cnt_next;
      m_resp_reg   <= pop ? head_onehot : '0;
      m_err_reg    <= do_timeout;
      if (do_normal) begin
        m_rdata_reg <= s_rdata;
      end else if (do_timeout) begin
        m_rdata_reg <= '0;
      end
      if (do_orphan) begin
        orphan_reg <= 1'b1;
      end
    end
  end

  assign m_resp       = m_resp_reg;
  assign m_rdata      = m_rdata_reg;
  assign m_err        = m_err_reg;
  assign orphan_err   = orphan_reg;
  assign late_pending = !late_zero;

endmodule

// File: doc/cross_bar_resp_router.md
# cross_bar_resp_router

Read-response return path for one slave port of the crossbar. Consumes the per-slave order FIFO (master numbers pushed at read-grant time), pops its head as the slave answers and routes the registered response back to the requesting master. It also generates a timeout error response for reads the slave never answers, and discards the late responses that follow such a timeout. One instance sits per slave, between the slave response port and the master response muxes.

## Interface
- MASTER_N, 4: number of masters; width of `m_resp`.
- MASTER_W, 2: master number width, equal to $clog2(MASTER_N).
- DATA_W, 32: read data width.
- TIMEOUT, 64: cycles a FIFO head may wait for `s_resp`; legal range is ≥2.
- LATE_W, 4: width of the late-response counter.

- clk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low.
- fifo_rd  out  1  pop the order FIFO head (combinational).
- fifo_rdata  in  MASTER_W  master number at the FIFO head.
- fifo_empty  in  1  order FIFO empty.
- s_resp  in  1  slave read-response valid, single-cycle pulse.
- s_rdata  in  DATA_W  slave read data, valid with `s_resp`.
- m_resp  out  MASTER_N  one-hot response strobe to the masters (registered).
- m_rdata  out  DATA_W  response data shared by all masters (registered).
- m_err  out  1  qualifies `m_resp`: timeout error response (registered).
- orphan_err  out  1  sticky: a response arrived with no outstanding read.
- late_pending  out  1  `late_cnt` is nonzero.

## Operation
- Internal state:
  - `timer`, $clog2(TIMEOUT) bits.
  - `late_cnt`, LATE_W bits.
- Head valid means `!fifo_empty`. `fifo_rdata` is stable while head valid, and FIFO pushes never alter it.
- Per cycle, priority order:
  1. **Discard.** `s_resp && late_cnt != 0`: response dropped, `late_cnt` decrements, no pop, `timer` cleared.
  2. **Normal.** `s_resp && late_cnt == 0 && head valid`: `fifo_rd` = 1. Next cycle `m_resp` = onehot(`fifo_rdata`), `m_rdata` = `s_rdata`, `m_err` = 0. `timer` cleared.
  3. **Orphan.** `s_resp && late_cnt == 0 && !head valid`: response dropped, `orphan_err` set. It stays set until reset.
  4. **Timeout.** No `s_resp`, head valid, `timer == TIMEOUT-1`:
     - `fifo_rd` = 1.
     - Next cycle `m_resp` = onehot(head), `m_err` = 1, `m_rdata` = 0.
     - `late_cnt` increments, saturating at 2^LATE_W-1.
     - `timer` cleared.
  5. **Count.** Otherwise, head valid: `timer` increments. Head not valid: `timer` cleared.
- `s_resp` arriving in the same cycle as timer expiry takes the normal path; no error is issued.
- `fifo_rd` is never asserted while `fifo_empty`.
- `m_resp`, `m_err` and `m_rdata` update every cycle:
  - `m_resp` and `m_err` are zero in any cycle not following a pop.
  - `m_rdata` holds its last value.
- Slave responses are in order, so late responses always precede responses to younger reads.

## Timing
- Reset is sampled at the clk edge with `aresetn` = 0 and may be applied mid-operation. The cycle after, all of the following are 0:
  - `m_resp`, `m_rdata`, `m_err`
  - `orphan_err`, `late_pending`
  - `timer`, `late_cnt`
- The order FIFO has its own reset. `fifo_rd` is 0 during reset.
- Response latency: `s_resp` in cycle N gives `m_resp` in cycle N+1, for exactly 1 cycle.
- Throughput: one response per cycle. Back-to-back `s_resp` pops consecutive heads, with `fifo_rdata` updating after each pop.
- Timeout: head valid from cycle T with no response gives `fifo_rd` in cycle T+TIMEOUT-1 and `m_resp`/`m_err` in cycle T+TIMEOUT.
- `late_pending` updates the cycle after `late_cnt` changes.

## Test plan
- **Normal:** MASTER_N=4. Push master 2, then `s_resp` with `s_rdata`=0xA5A5_0001 one cycle later → next cycle `m_resp`=4'b0100, `m_rdata`=0xA5A5_0001, `m_err`=0; `fifo_empty` then high.
- **Back-to-back:** push masters 0, 3, 1, then three consecutive `s_resp` with data 0x10, 0x11, 0x12 → `m_resp` = 0001, 1000, 0010 in three consecutive cycles with matching data; no bubbles.
- **Timeout then late response:** TIMEOUT=8. Push master 1, no response → `m_resp`=0010 with `m_err`=1 exactly 8 cycles after head valid, and `late_pending`=1. Push master 3, then two `s_resp` → the first is discarded and `late_pending` goes to 0; the second gives `m_resp`=1000, `m_err`=0.
- **Race:** `s_resp` in the cycle `timer`=TIMEOUT-1 → normal response, `m_err`=0, `late_cnt` stays 0.
- **Orphan:** `s_resp` with FIFO empty and `late_cnt`=0 → no `m_resp`, no `fifo_rd`, `orphan_err`=1 held until reset.
- **Reset mid-operation:** `aresetn` low for one cycle while `late_cnt`=2 and `timer`=5 → all outputs and counters are 0 the next cycle, and a fresh push/response round-trip then works.
